edge_event_unit: RTL and testbench

Multi-channel successor to the single-input pulse detector: synchronises CHANNELS asynchronous level inputs, debounces each one, and emits a one-cycle pulse per qualified edge under a per-channel mode (off/rise/fall/both). Each channel also keeps a sticky pending flag and a saturating event counter, and the pending flags are ORed into one interrupt line. It sits between raw external pins (buttons, sensor strobes) and control logic or an interrupt aggregator.

---
 rtl/edge_event_if.sv | 27 ++
 rtl/edge_event_unit.sv | 169 ++++++++++++++++
 tb/tb_edge_event_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/edge_event_if.sv
// Bundles the per-channel pin, mode, clear and status signals of edge_event_unit.
// The slave modport is the unit's view; the master modport is the controller's view.
interface edge_event_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]   p_i;
  logic [2*CHANNELS-1:0] mode_i;
  logic [CHANNELS-1:0]   clr_i;
  logic [SelW-1:0]       cnt_sel_i;
  logic [CHANNELS-1:0]   r_o;
  logic [CHANNELS-1:0]   pend_o;
  logic                  irq_o;
  logic [CNT_W-1:0]      cnt_o;

  modport slave (
    input  p_i, mode_i, clr_i, cnt_sel_i,
    output r_o, pend_o, irq_o, cnt_o
  );

  modport master (
    output p_i, mode_i, clr_i, cnt_sel_i,
    input  r_o, pend_o, irq_o, cnt_o
  );
endinterface

// File: rtl/edge_event_unit.sv
// Multi-channel synchronise/debounce/edge-detect unit with sticky pending flags,
// saturating per-channel event counters and an ORed interrupt line.
module edge_event_unit #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input logic        clk_i,
  input logic        rst_ni,
  edge_event_if.slave bus
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [DbW-1:0]   DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StLow, StLowPend, StHigh, StHighPend} db_state_e;

  logic [SYNC_STAGES-1:0] sync_q   [CHANNELS];
  db_state_e              state_q  [CHANNELS];
  db_state_e              state_d  [CHANNELS];
  logic [DbW-1:0]         db_cnt_q [CHANNELS];
  logic [DbW-1:0]         db_cnt_d [CHANNELS];
  logic [CNT_W-1:0]       ev_cnt_q [CHANNELS];
  logic [CNT_W-1:0]       ev_cnt_d [CHANNELS];

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] r_q, r_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                irq_q;
  logic [CNT_W-1:0]    cnt_mux;

  always_comb begin
    s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]  = state_q[c];
      db_cnt_d[c] = db_cnt_q[c];
      unique case (state_q[c])
        StLow: begin
          if (s[c]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[c] = StHigh;
              rise[c]    = 1'b1;
            end else begin
              state_d[c]  = StLowPend;
              db_cnt_d[c] = DbW'(1);
            end
          end
        end
        StLowPend: begin
          if (!s[c]) begin
            state_d[c]  = StLow;
            db_cnt_d[c] = '0;
          end else if (db_cnt_q[c] == DbLast) begin
            state_d[c]  = StHigh;
            db_cnt_d[c] = '0;
            rise[c]     = 1'b1;
          end else begin
            db_cnt_d[c] = db_cnt_q[c] + DbW'(1);
          end
        end
        StHigh: begin
          if (!s[c]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[c] = StLow;
              fall[c]    = 1'b1;
            end else begin
              state_d[c]  = StHighPend;
              db_cnt_d[c] = DbW'(1);
            end
          end
        end
        StHighPend: begin
          if (s[c]) begin
            state_d[c]  = StHigh;
            db_cnt_d[c] = '0;
          end else if (db_cnt_q[c] == DbLast) begin
            state_d[c]  = StLow;
            db_cnt_d[c] = '0;
            fall[c]     = 1'b1;
          end else begin
            db_cnt_d[c] = db_cnt_q[c] + DbW'(1);
          end
        end
        default: begin
          state_d[c]  = StLow;
          db_cnt_d[c] = '0;
        end
      endcase
    end
  end

  // A qualified edge overrides a same-cycle clear: the counter restarts at 1.
  always_comb begin
    logic hit;
    r_d    = '0;
    pend_d = pend_q;
    for (int c = 0; c < CHANNELS; c++) begin
      hit         = (rise[c] & bus.mode_i[2*c]) | (fall[c] & bus.mode_i[2*c+1]);
      r_d[c]      = hit;
      ev_cnt_d[c] = ev_cnt_q[c];
      if (bus.clr_i[c]) begin
        pend_d[c]   = 1'b0;
        ev_cnt_d[c] = '0;
      end
      if (hit) begin
        pend_d[c] = 1'b1;
        if (bus.clr_i[c]) begin
          ev_cnt_d[c] = CNT_W'(1);
        end else if (ev_cnt_q[c] != CntMax) begin
          ev_cnt_d[c] = ev_cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    cnt_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.cnt_sel_i == SelW'(c)) begin
        cnt_mux = ev_cnt_q[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c]   <= '0;
        state_q[c]  <= StLow;
        db_cnt_q[c] <= '0;
        ev_cnt_q[c] <= '0;
      end
      r_q    <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c]   <= {sync_q[c][SYNC_STAGES-2:0], bus.p_i[c]};
        state_q[c]  <= state_d[c];
        db_cnt_q[c] <= db_cnt_d[c];
        ev_cnt_q[c] <= ev_cnt_d[c];
      end
      r_q    <= r_d;
      pend_q <= pend_d;
      irq_q  <= |pend_q;
    end
  end

  assign bus.r_o    = r_q;
  assign bus.pend_o = pend_q;
  assign bus.irq_o  = irq_q;
  assign bus.cnt_o  = cnt_mux;

endmodule

// File: tb/tb_edge_event_unit.sv
// Directed bench for edge_event_unit: a default 4-channel instance and a
// 3-channel instance with 2-bit counters for saturation and select range.
module tb_edge_event_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  edge_event_if #(.CHANNELS(4), .CNT_W(8)) bus0 ();
  edge_event_if #(.CHANNELS(3), .CNT_W(2)) bus1 ();

  edge_event_unit #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)
  ) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus0)
  );

  edge_event_unit #(
    .CHANNELS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)
  ) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cnt0(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    bus0.cnt_sel_i = sel;
    #1;
    check(tag, 32'(bus0.cnt_o), 32'(exp));
  endtask

  task automatic cnt1(input string tag, input logic [1:0] sel, input logic [1:0] exp);
    bus1.cnt_sel_i = sel;
    #1;
    check(tag, 32'(bus1.cnt_o), 32'(exp));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus0.p_i       = '0;
    bus0.mode_i    = 8'b11_01_01_01;
    bus0.clr_i     = '0;
    bus0.cnt_sel_i = '0;
    bus1.p_i       = '0;
    bus1.mode_i    = 6'b11_11_11;
    bus1.clr_i     = '0;
    bus1.cnt_sel_i = '0;

    // Reset state
    tick(3);
    check("rst_r", 32'(bus0.r_o), 32'h0);
    check("rst_pend", 32'(bus0.pend_o), 32'h0);
    check("rst_irq", 32'(bus0.irq_o), 32'h0);
    cnt0("rst_cnt", 2'd0, 8'd0);
    rst_n = 1'b1;
    tick(2);

    // Rise latency on channel 0: pulse after edge k+5, irq one edge later
    bus0.p_i[0] = 1'b1;
    tick(5);
    check("lat_r_k4", 32'(bus0.r_o), 32'h0);
    check("lat_pend_k4", 32'(bus0.pend_o), 32'h0);
    tick(1);
    check("lat_r_k5", 32'(bus0.r_o), 32'h1);
    check("lat_pend_k5", 32'(bus0.pend_o), 32'h1);
    check("lat_irq_k5", 32'(bus0.irq_o), 32'h0);
    cnt0("lat_cnt_k5", 2'd0, 8'd1);
    tick(1);
    check("lat_r_k6", 32'(bus0.r_o), 32'h0);
    check("lat_irq_k6", 32'(bus0.irq_o), 32'h1);

    // Glitches of 2 and 3 cycles on channels 1 (mode 01) and 3 (mode 11)
    bus0.p_i[1] = 1'b1; bus0.p_i[3] = 1'b1;
    tick(2);
    bus0.p_i[1] = 1'b0; bus0.p_i[3] = 1'b0;
    tick(8);
    bus0.p_i[1] = 1'b1; bus0.p_i[3] = 1'b1;
    tick(3);
    bus0.p_i[1] = 1'b0; bus0.p_i[3] = 1'b0;
    tick(8);
    check("glitch_pend", 32'(bus0.pend_o), 32'h1);
    cnt0("glitch_cnt1", 2'd1, 8'd0);
    cnt0("glitch_cnt3", 2'd3, 8'd0);

    // 4-cycle pulse: rise on both, fall only on channel 3
    bus0.p_i[1] = 1'b1; bus0.p_i[3] = 1'b1;
    tick(4);
    bus0.p_i[1] = 1'b0; bus0.p_i[3] = 1'b0;
    tick(2);
    check("pulse4_rise", 32'(bus0.r_o), 32'hA);
    tick(1);
    check("pulse4_gap", 32'(bus0.r_o), 32'h0);
    tick(3);
    check("pulse4_fall", 32'(bus0.r_o), 32'h8);
    tick(5);
    cnt0("pulse4_cnt1", 2'd1, 8'd1);
    cnt0("pulse4_cnt3", 2'd3, 8'd2);
    check("pulse4_pend", 32'(bus0.pend_o), 32'hB);

    // Return channel 0 low (mode 01, fall unqualified), then clear everything
    bus0.p_i[0] = 1'b0;
    tick(10);
    check("fall_unq_pend", 32'(bus0.pend_o), 32'hB);
    bus0.clr_i = 4'hF;
    tick(1);
    bus0.clr_i = 4'h0;
    check("clr_pend", 32'(bus0.pend_o), 32'h0);
    cnt0("clr_cnt3", 2'd3, 8'd0);
    tick(1);
    check("clr_irq", 32'(bus0.irq_o), 32'h0);

    // Mode coverage: 00/01/10/11 on channels 0..3, 10 toggles 10 cycles apart
    bus0.mode_i = 8'b11_10_01_00;
    for (int t = 1; t <= 10; t++) begin
      bus0.p_i = (t % 2 == 1) ? 4'hF : 4'h0;
      tick(6);
      check($sformatf("mode_r_t%0d", t), 32'(bus0.r_o), (t % 2 == 1) ? 32'hA : 32'hC);
      tick(4);
    end
    check("mode_r_idle", 32'(bus0.r_o), 32'h0);
    cnt0("mode_cnt0", 2'd0, 8'd0);
    cnt0("mode_cnt1", 2'd1, 8'd5);
    cnt0("mode_cnt2", 2'd2, 8'd5);
    cnt0("mode_cnt3", 2'd3, 8'd10);

    // Mode change alone makes no pulse; then clear coincides with the flip on channel 2
    bus0.mode_i = 8'b11_11_01_00;
    tick(2);
    check("modechg_r", 32'(bus0.r_o), 32'h0);
    bus0.p_i[2] = 1'b1;
    tick(5);
    bus0.clr_i[2] = 1'b1;
    tick(1);
    bus0.clr_i[2] = 1'b0;
    check("clr_edge_r", 32'(bus0.r_o), 32'h4);
    check("clr_edge_pend", 32'(bus0.pend_o[2]), 32'h1);
    cnt0("clr_edge_cnt", 2'd2, 8'd1);

    // Reset during LOW_PEND on channel 1: outputs drop immediately, no pulse afterwards
    bus0.p_i[1] = 1'b1;
    bus0.cnt_sel_i = 2'd3;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_r", 32'(bus0.r_o), 32'h0);
    check("mid_rst_pend", 32'(bus0.pend_o), 32'h0);
    check("mid_rst_irq", 32'(bus0.irq_o), 32'h0);
    check("mid_rst_cnt", 32'(bus0.cnt_o), 32'h0);
    bus0.p_i = 4'h0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("post_rst_pend", 32'(bus0.pend_o), 32'h0);

    // Saturation with 2-bit counters: 6 edges on all 3 channels read as 3
    for (int t = 0; t < 6; t++) begin
      bus1.p_i = ~bus1.p_i;
      tick(8);
    end
    cnt1("sat_cnt0", 2'd0, 2'd3);
    cnt1("sat_cnt2", 2'd2, 2'd3);
    cnt1("sel_oor", 2'd3, 2'd0);
    check("sat_pend", 32'(bus1.pend_o), 32'h7);
    check("sat_irq", 32'(bus1.irq_o), 32'h1);
    bus1.clr_i = 3'b111;
    tick(1);
    bus1.clr_i = 3'b000;
    check("sat_clr_pend", 32'(bus1.pend_o), 32'h0);
    check("sat_clr_irq_lag", 32'(bus1.irq_o), 32'h1);
    cnt1("sat_clr_cnt", 2'd0, 2'd0);
    tick(1);
    check("sat_clr_irq", 32'(bus1.irq_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
